// File: rtl/md_unit_pkg.sv
// Shared op codes and FSM state type for the multiply/divide unit.
package md_unit_pkg;

  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_md_op(input logic [MD_OP_W-1:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational product/quotient engine: signed and unsigned multiply and divide
// producing the HI/LO pair, plus a divide-by-zero flag.
module md_calc
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   res_hi,
  output logic [WIDTH-1:0]   res_lo,
  output logic               div0
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Returns {remainder, quotient}; the MIN_NEG / -1 overflow is pinned so it never traps.
  function automatic logic [2*WIDTH-1:0] sdiv(input logic signed [WIDTH-1:0] n,
                                               input logic signed [WIDTH-1:0] d);
    logic signed [WIDTH-1:0] q;
    logic signed [WIDTH-1:0] r;
    if (d == '0) begin
      q = '0;
      r = '0;
    end else if ((n == MIN_NEG) && (d == '1)) begin
      q = MIN_NEG;
      r = '0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic        [2*WIDTH-1:0] div_s;
  logic        [WIDTH-1:0]   q_u;
  logic        [WIDTH-1:0]   r_u;

  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign div_s  = sdiv($signed(a), $signed(b));
  assign div0   = (b == '0);
  assign q_u    = div0 ? '0 : (a / b);
  assign r_u    = div0 ? '0 : (a % b);

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV:   {res_hi, res_lo} = div_s;
      MD_DIVU: begin
        res_hi = r_u;
        res_lo = q_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit: owns HI/LO, holds the result in pending
// registers for a fixed busy period, then commits it.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  input  logic               rd_hi,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   md_rdata
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             launch, commit, mthi_wr, mtlo_wr;

  logic [WIDTH-1:0] calc_hi, calc_lo;
  logic             calc_div0;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic             pend_div0;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op     (md_op),
    .a      (rs_val),
    .b      (rt_val),
    .res_hi (calc_hi),
    .res_lo (calc_lo),
    .div0   (calc_div0)
  );

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    launch    = 1'b0;
    commit    = 1'b0;
    mthi_wr   = 1'b0;
    mtlo_wr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_md_op(md_op)) begin
            launch    = 1'b1;
            state_nxt = ST_RUN;
            cnt_nxt   = is_mult_op(md_op) ? MULT_LOAD : DIV_LOAD;
          end else if (md_op == MD_MTHI) begin
            mthi_wr = 1'b1;
          end else if (md_op == MD_MTLO) begin
            mtlo_wr = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here, mthi/mtlo included
        if (cnt_q == CNT_ONE) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Launch: capture the result now, operands need not be held while busy
  always_ff @(posedge clk) begin
    if (launch) begin
      pend_hi   <= calc_hi;
      pend_lo   <= calc_lo;
      pend_div0 <= calc_div0;
    end
  end

  // Commit: HI/LO only ever change on a finished op or mthi/mtlo
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      if (!pend_div0) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else begin
      if (mthi_wr) hi <= rs_val;
      if (mtlo_wr) lo <= rs_val;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign md_rdata = rd_hi ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected HI/LO pushed to a scoreboard at issue,
// popped and compared when busy drops.
module tb_md_unit;
  import md_unit_pkg::*;

  logic               clk = 1'b0;
  logic               reset, start, rd_hi;
  logic [MD_OP_W-1:0] md_op;
  logic [31:0]        rs_val, rt_val;
  logic               busy;
  logic [31:0]        hi, lo, md_rdata;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .rd_hi    (rd_hi),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .md_rdata (md_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
  endtask

  task automatic issue(input logic [MD_OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op  = op;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    step();
    start  = 1'b0;
    md_op  = MD_NONE;
  endtask

  task automatic drain_and_check(input int already, input int n);
    int   cyc;
    exp_t e;
    cyc = already;
    while (busy && cyc < 200) begin
      step();
      cyc++;
    end
    e = sb.pop_front();
    chk({e.tag, "_cycles"}, cyc, n);
    chk({e.tag, "_hi"}, hi, e.hi);
    chk({e.tag, "_lo"}, lo, e.lo);
    rd_hi = 1'b1;
    #1;
    chk({e.tag, "_rdata"}, md_rdata, e.hi);
    rd_hi = 1'b0;
  endtask

  task automatic run_md(input string tag, input logic [MD_OP_W-1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int n);
    logic [31:0] old_lo;
    exp_t        e;
    old_lo = lo;
    e.tag = tag;
    e.hi  = eh;
    e.lo  = el;
    sb.push_back(e);
    issue(op, a, b);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    rd_hi = 1'b0;
    #1;
    chk({tag, "_rdata_old"}, md_rdata, old_lo);
    drain_and_check(0, n);
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b1;
    md_op  = MD_MTHI;
    rs_val = 32'hDEAD;
    rt_val = 32'h0;
    rd_hi  = 1'b0;
    step();
    step();
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    reset = 1'b1;
    start = 1'b0;
    md_op = MD_NONE;
    step();

    issue(MD_MTHI, 32'h1234, 32'h0);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    rd_hi = 1'b1;
    #1;
    chk("mthi_rdata", md_rdata, 32'h1234);
    issue(MD_MTLO, 32'hABCD, 32'h0);
    chk("mtlo_lo", lo, 32'hABCD);
    chk("mtlo_busy", {31'b0, busy}, 32'd0);
    rd_hi = 1'b0;
    #1;
    chk("mtlo_rdata", md_rdata, 32'hABCD);

    run_md("mult",  MD_MULT,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    run_md("multu", MD_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 5);
    run_md("div",   MD_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_md("divu",  MD_DIVU,  32'h7,        32'h2, 32'h1,        32'h3,        10);
    run_md("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);

    issue(MD_MTHI, 32'h5, 32'h0);
    issue(MD_MTLO, 32'h6, 32'h0);
    run_md("div0", MD_DIV, 32'h1234, 32'h0, 32'h5, 32'h6, 10);

    // abort a multiply with reset on its third busy cycle
    issue(MD_MULT, 32'h3, 32'h4);
    step();
    step();
    chk("abort_busy_pre", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    step();
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    reset = 1'b1;
    repeat (6) step();
    chk("abort_hi_late", hi, 32'h0);
    chk("abort_lo_late", lo, 32'h0);
    chk("abort_busy_late", {31'b0, busy}, 32'd0);

    // start while busy must be ignored
    begin
      exp_t e;
      e.tag = "div_busy_start";
      e.hi  = 32'd2;
      e.lo  = 32'd14;
      sb.push_back(e);
    end
    issue(MD_DIV, 32'd100, 32'd7);
    step();
    $display("WARN: start asserted while busy; MTLO 0x77 expected to be ignored");
    md_op  = MD_MTLO;
    rs_val = 32'h77;
    start  = 1'b1;
    step();
    start  = 1'b0;
    md_op  = MD_NONE;
    chk("ignored_lo", lo, 32'h0);
    chk("ignored_busy", {31'b0, busy}, 32'd1);
    drain_and_check(2, 10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
